lab3_mem_nway_tag_unit: RTL and testbench
=========================================

# lab3_mem_nway_tag_unit

Parametrised N-way set-associative tag/state store for the next-generation blocking cache. It holds tag, valid and dirty bits per line and tree pseudo-LRU state per set. It performs combinational lookup with hit and victim selection. A multi-cycle flush engine walks every line, hands each dirty line out through a val/rdy port, and invalidates every line. The cache FSM drives lookups and updates. The datapath consumes hit way, victim way and victim tag for way muxing and evict-address formation.

## Interface
- p_num_ways, 2: associativity; power of two, 2..8; wyw = max(1, clog2(p_num_ways))
- p_num_sets, 8: sets per way; power of two ≥2; idw = clog2(p_num_sets)
- p_tag_width, 28: stored tag bits
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- lkup_idx  in  idw  set index for lookup
- lkup_tag  in  p_tag_width  tag compared against all ways of lkup_idx
- hit  out  1  some way valid with matching tag; forced 0 while busy
- hit_way  out  wyw  matching way (0 when !hit)
- victim_way  out  wyw  replacement choice for lkup_idx
- victim_valid / victim_dirty  out  1 each  V/D of victim_way
- victim_tag  out  p_tag_width  stored tag of victim_way
- upd_en  in  1  apply update at clock edge (ignored while busy)
- upd_op  in  2  0 touch, 1 fill-clean, 2 mark-dirty, 3 invalidate
- upd_idx / upd_way / upd_tag  in  idw / wyw / p_tag_width  update target and fill tag
- flush_req  in  1  start flush (sampled in IDLE only)
- busy  out  1  flush in progress
- flush_evict_val  out  1  dirty line offered
- flush_evict_rdy  in  1  consumer accepts
- flush_evict_idx / flush_evict_tag  out  idw / p_tag_width  offered line
- flush_done  out  1  one-cycle pulse at flush end

## Operation
- Lookup is purely combinational from state and lkup_* inputs.
- Victim selection:
  - lowest-index invalid way if any;
  - else follow the PLRU tree.
- PLRU tree: p_num_ways-1 bits per set, heap-ordered (node 0 = root, children 2n+1 and 2n+2).
  - Bit 0 selects the lower-index subtree; bit 1 selects the upper-index subtree.
  - Access to way w sets each bit on the root-to-leaf path to point away from w.
- upd_op semantics:
  - touch: PLRU access only.
  - fill-clean: tag←upd_tag, V=1, D=0, PLRU access.
  - mark-dirty: D=1, PLRU access.
  - invalidate: V=0, D=0, PLRU unchanged.
- Flush FSM states: IDLE, SCAN, EVICT, DONE.
  - IDLE→SCAN on flush_req; the entry counter is {set,way}, cleared to 0.
  - SCAN, entry V&D: → EVICT.
  - SCAN, otherwise: clear V/D of the entry and advance. The last entry goes → DONE.
  - EVICT: flush_evict_val=1, idx/tag held stable. On val&rdy, clear V/D, advance (last → DONE), else stay.
  - DONE: flush_done=1 for one cycle → IDLE.
- PLRU bits are not modified by flush.
- Scan order: set 0..p_num_sets-1 outer, way 0..p_num_ways-1 inner. The counter wraps to 0 only via IDLE.

## Timing
- Reset values:
  - all V=0, D=0, PLRU=0, FSM=IDLE;
  - busy, flush_evict_val, flush_done = 0;
  - hit=0, victim_way=0.
- Tag storage is not reset.
- Lookup latency 0 cycles. Update effects are visible in the cycle after the edge.
- busy rises the cycle after flush_req is accepted. It stays high through SCAN, EVICT and DONE, and falls the cycle after DONE.
- A clean flush keeps busy high for exactly p_num_sets·p_num_ways + 1 cycles.
- Each dirty line adds 1 + (cycles rdy low while offered).
- Simultaneous upd_en and flush_req in IDLE: the update applies, then the flush scans the updated state.
- flush_req while busy is ignored. upd_en while busy is ignored.
- Reset mid-flush: immediate IDLE, all state cleared, no flush_done, val drops.
- flush_evict_val must not depend combinationally on flush_evict_rdy.

## Test plan
- Reset, 4-way/8-set/tag 28: any lookup → hit=0, victim_way=0, victim_valid=0, busy=0.
- Fill idx 3 with tags 0xA, 0xB, 0xC, 0xD, each to the reported victim_way → victims 0, 1, 2, 3 in order. Lookup 0xC → hit=1, hit_way=2.
- Continue idx 3:
  - victim_way=0;
  - touch way 0 → victim 2;
  - touch way 2 → victim 1.
  - Invalidate way 3 → victim 3.
- Mark-dirty idx 3 way 1 with victim_way=1 → victim_dirty=1, victim_tag=0xB. Another set is unaffected.
- Flush with dirty (3,1) tag 0xB and (5,0) tag 0x77; rdy low 3 cycles on the first offer, then high:
  - offers (3, 0xB) then (5, 0x77);
  - busy high 38 cycles, flush_done a single pulse;
  - afterwards all lookups miss.
- Robustness:
  - flush_req during busy → no restart;
  - upd_en fill during busy → no effect;
  - reset asserted in EVICT → val=0, busy=0 next cycle, all lines invalid.

Source files
------------

// File: rtl/lab3_mem_nway_tag_unit.sv
// N-way set-associative tag/valid/dirty store with tree pseudo-LRU per set,
// combinational lookup/victim selection and a val/rdy flush-walk engine.
module lab3_mem_nway_tag_unit #(
    parameter int p_num_ways  = 2,
    parameter int p_num_sets  = 8,
    parameter int p_tag_width = 28,
    localparam int WYW = (p_num_ways > 1) ? $clog2(p_num_ways) : 1,
    localparam int IDW = $clog2(p_num_sets)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [IDW-1:0]         lkup_idx_i,
    input  logic [p_tag_width-1:0] lkup_tag_i,
    output logic                   hit_o,
    output logic [WYW-1:0]         hit_way_o,
    output logic [WYW-1:0]         victim_way_o,
    output logic                   victim_valid_o,
    output logic                   victim_dirty_o,
    output logic [p_tag_width-1:0] victim_tag_o,
    input  logic                   upd_en_i,
    input  logic [1:0]             upd_op_i,
    input  logic [IDW-1:0]         upd_idx_i,
    input  logic [WYW-1:0]         upd_way_i,
    input  logic [p_tag_width-1:0] upd_tag_i,
    input  logic                   flush_req_i,
    output logic                   busy_o,
    output logic                   flush_evict_val_o,
    input  logic                   flush_evict_rdy_i,
    output logic [IDW-1:0]         flush_evict_idx_o,
    output logic [p_tag_width-1:0] flush_evict_tag_o,
    output logic                   flush_done_o
);

    localparam int PLW = p_num_ways - 1;
    localparam int CW  = IDW + WYW;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EVICT, S_DONE} state_t;

    logic [p_num_sets-1:0][p_num_ways-1:0] v_q, d_q;
    logic [p_num_sets-1:0][PLW-1:0]        plru_q;
    logic [p_tag_width-1:0]                tag_q [p_num_sets][p_num_ways];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clr_en;
    logic [IDW-1:0]  ent_set;
    logic [WYW-1:0]  ent_way;
    logic            ent_last;
    logic            upd_go;

    // Walk the heap-ordered tree from the root; a 0 bit steers to the lower half.
    function automatic logic [WYW-1:0] plru_victim(input logic [PLW-1:0] bits);
        logic [WYW-1:0] w;
        logic           b;
        int             n;
        w = '0;
        n = 0;
        for (int d = 0; d < WYW; d++) begin
            b = 1'b0;
            for (int k = 0; k < PLW; k++)
                if (n == k) b = bits[k];
            w = (w << 1) | WYW'(b);
            n = 2 * n + 1 + int'(b);
        end
        return w;
    endfunction

    function automatic logic [PLW-1:0] plru_touch(input logic [PLW-1:0] bits,
                                                  input logic [WYW-1:0] way);
        logic [PLW-1:0] nb;
        logic [WYW-1:0] wr;
        logic           dir;
        int             n;
        nb = bits;
        wr = way;
        n  = 0;
        for (int d = 0; d < WYW; d++) begin
            dir = wr[WYW-1];
            for (int k = 0; k < PLW; k++)
                if (n == k) nb[k] = ~dir;
            wr = wr << 1;
            n  = 2 * n + 1 + int'(dir);
        end
        return nb;
    endfunction

    // ---------------- lookup / victim ----------------
    logic           hit_raw, inv_any;
    logic [WYW-1:0] hit_w, inv_w, vic_w;

    always_comb begin
        hit_raw = 1'b0;
        hit_w   = '0;
        inv_any = 1'b0;
        inv_w   = '0;
        for (int w = p_num_ways - 1; w >= 0; w--) begin
            if (v_q[lkup_idx_i][w] && tag_q[lkup_idx_i][w] == lkup_tag_i) begin
                hit_raw = 1'b1;
                hit_w   = WYW'(w);
            end
            if (!v_q[lkup_idx_i][w]) begin
                inv_any = 1'b1;
                inv_w   = WYW'(w);
            end
        end
        vic_w = inv_any ? inv_w : plru_victim(plru_q[lkup_idx_i]);
    end

    assign busy_o         = (state_q != S_IDLE);
    assign hit_o          = hit_raw & ~busy_o;
    assign hit_way_o      = hit_o ? hit_w : '0;
    assign victim_way_o   = vic_w;
    assign victim_valid_o = v_q[lkup_idx_i][vic_w];
    assign victim_dirty_o = d_q[lkup_idx_i][vic_w];
    assign victim_tag_o   = tag_q[lkup_idx_i][vic_w];

    // ---------------- flush engine ----------------
    assign ent_set  = cnt_q[CW-1:WYW];
    assign ent_way  = cnt_q[WYW-1:0];
    assign ent_last = &cnt_q;

    assign flush_evict_val_o = (state_q == S_EVICT);
    assign flush_evict_idx_o = ent_set;
    assign flush_evict_tag_o = tag_q[ent_set][ent_way];
    assign flush_done_o      = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_req_i) begin
                    state_d = S_SCAN;
                    cnt_d   = '0;
                end
            end
            S_SCAN: begin
                if (v_q[ent_set][ent_way] && d_q[ent_set][ent_way]) begin
                    state_d = S_EVICT;
                end else begin
                    clr_en = 1'b1;
                    if (ent_last) state_d = S_DONE;
                    else          cnt_d   = cnt_q + CW'(1);
                end
            end
            S_EVICT: begin
                if (flush_evict_rdy_i) begin
                    clr_en = 1'b1;
                    if (ent_last) state_d = S_DONE;
                    else begin
                        state_d = S_SCAN;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- state arrays ----------------
    assign upd_go = upd_en_i && (state_q == S_IDLE);

    // Updates and flush clears never coincide: one needs IDLE, the other doesn't.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= '0;
            d_q    <= '0;
            plru_q <= '0;
        end else begin
            if (upd_go) begin
                case (upd_op_i)
                    2'd0: plru_q[upd_idx_i] <= plru_touch(plru_q[upd_idx_i], upd_way_i);
                    2'd1: begin
                        v_q[upd_idx_i][upd_way_i] <= 1'b1;
                        d_q[upd_idx_i][upd_way_i] <= 1'b0;
                        plru_q[upd_idx_i]         <= plru_touch(plru_q[upd_idx_i], upd_way_i);
                    end
                    2'd2: begin
                        d_q[upd_idx_i][upd_way_i] <= 1'b1;
                        plru_q[upd_idx_i]         <= plru_touch(plru_q[upd_idx_i], upd_way_i);
                    end
                    2'd3: begin
                        v_q[upd_idx_i][upd_way_i] <= 1'b0;
                        d_q[upd_idx_i][upd_way_i] <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (clr_en) begin
                v_q[ent_set][ent_way] <= 1'b0;
                d_q[ent_set][ent_way] <= 1'b0;
            end
        end
    end

    // Tags are qualified by V, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (upd_go && upd_op_i == 2'd1)
            tag_q[upd_idx_i][upd_way_i] <= upd_tag_i;
    end

endmodule

// File: tb/tb_lab3_mem_nway_tag_unit.sv
// Directed bench for lab3_mem_nway_tag_unit: 4 ways, 8 sets, 28-bit tags.
module tb_lab3_mem_nway_tag_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  lkup_idx;
    logic [27:0] lkup_tag;
    logic        hit;
    logic [1:0]  hit_way, victim_way;
    logic        victim_valid, victim_dirty;
    logic [27:0] victim_tag;
    logic        upd_en;
    logic [1:0]  upd_op;
    logic [2:0]  upd_idx;
    logic [1:0]  upd_way;
    logic [27:0] upd_tag;
    logic        flush_req, busy, flush_evict_val, flush_evict_rdy, flush_done;
    logic [2:0]  flush_evict_idx;
    logic [27:0] flush_evict_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lab3_mem_nway_tag_unit #(.p_num_ways(4), .p_num_sets(8), .p_tag_width(28)) dut (
        .clk_i(clk), .reset_i(reset),
        .lkup_idx_i(lkup_idx), .lkup_tag_i(lkup_tag),
        .hit_o(hit), .hit_way_o(hit_way),
        .victim_way_o(victim_way), .victim_valid_o(victim_valid),
        .victim_dirty_o(victim_dirty), .victim_tag_o(victim_tag),
        .upd_en_i(upd_en), .upd_op_i(upd_op), .upd_idx_i(upd_idx),
        .upd_way_i(upd_way), .upd_tag_i(upd_tag),
        .flush_req_i(flush_req), .busy_o(busy),
        .flush_evict_val_o(flush_evict_val), .flush_evict_rdy_i(flush_evict_rdy),
        .flush_evict_idx_o(flush_evict_idx), .flush_evict_tag_o(flush_evict_tag),
        .flush_done_o(flush_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [1:0] op, input logic [2:0] idx,
                          input logic [1:0] way, input logic [27:0] tag);
        upd_op = op; upd_idx = idx; upd_way = way; upd_tag = tag; upd_en = 1'b1;
        step();
        upd_en = 1'b0;
    endtask

    task automatic look(input logic [2:0] idx, input logic [27:0] tag);
        lkup_idx = idx; lkup_tag = tag;
        #1;
    endtask

    // Drives rdy and optional mid-flush disturbances; reports what it saw.
    task automatic run_flush(input int low_cycles, input bit inject,
                             output int busy_cyc, output int done_cnt, output int n_off,
                             output logic [2:0] o0_idx, output logic [27:0] o0_tag,
                             output logic [2:0] o1_idx, output logic [27:0] o1_tag,
                             output bit stall_ok, output bit hit_busy, output bit tmo);
        int          low_left;
        bit          first, have_s;
        logic [2:0]  s_idx;
        logic [27:0] s_tag;
        busy_cyc = 0; done_cnt = 0; n_off = 0;
        o0_idx = '0; o0_tag = '0; o1_idx = '0; o1_tag = '0;
        stall_ok = 1'b1; hit_busy = 1'b0; tmo = 1'b0;
        low_left = low_cycles; first = 1'b1; have_s = 1'b0;
        s_idx = '0; s_tag = '0;
        while (busy === 1'b1 && busy_cyc < 500) begin
            busy_cyc++;
            if (busy_cyc == 1) hit_busy = hit;
            if (flush_done === 1'b1) done_cnt++;
            if (inject) begin
                upd_op = 2'd1; upd_idx = 3'd0; upd_way = 2'd0; upd_tag = 28'h55;
                upd_en    = (busy_cyc == 5);
                flush_req = (busy_cyc == 10);
            end
            if (flush_evict_val === 1'b1) begin
                if (first && low_left > 0) begin
                    if (!have_s) begin
                        s_idx = flush_evict_idx; s_tag = flush_evict_tag; have_s = 1'b1;
                    end else if (flush_evict_idx !== s_idx || flush_evict_tag !== s_tag) begin
                        stall_ok = 1'b0;
                    end
                    low_left--;
                    flush_evict_rdy = 1'b0;
                end else begin
                    if (have_s && first && (flush_evict_idx !== s_idx || flush_evict_tag !== s_tag))
                        stall_ok = 1'b0;
                    flush_evict_rdy = 1'b1;
                    first = 1'b0;
                    if (n_off == 0) begin o0_idx = flush_evict_idx; o0_tag = flush_evict_tag; end
                    else if (n_off == 1) begin o1_idx = flush_evict_idx; o1_tag = flush_evict_tag; end
                    n_off++;
                end
            end else begin
                flush_evict_rdy = 1'b1;
            end
            step();
        end
        tmo = (busy_cyc >= 500);
        upd_en = 1'b0; flush_req = 1'b0; flush_evict_rdy = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        look(3'd0, 28'h0);
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b exp=0", hit); end
        total++; if (victim_way !== 2'd0) begin bad++; $display("FAIL reset_victim_way got=%0d exp=0", victim_way); end
        total++; if (victim_valid !== 1'b0) begin bad++; $display("FAIL reset_victim_valid got=%0b exp=0", victim_valid); end
        total++; if (busy !== 1'b0 || flush_evict_val !== 1'b0 || flush_done !== 1'b0) begin
            bad++; $display("FAIL reset_flush_outs busy=%0b val=%0b done=%0b exp=000", busy, flush_evict_val, flush_done);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            look(3'd3, 28'h0);
            total++; if (victim_way !== 2'(i)) begin bad++; $display("FAIL fill_victim[%0d] got=%0d exp=%0d", i, victim_way, i); end
            do_upd(2'd1, 3'd3, 2'(i), 28'hA + 28'(i));
        end
        look(3'd3, 28'hC);
        total++; if (hit !== 1'b1 || hit_way !== 2'd2) begin bad++; $display("FAIL fill_hit got=%0b/%0d exp=1/2", hit, hit_way); end
        look(3'd3, 28'hE);
        total++; if (hit !== 1'b0 || hit_way !== 2'd0) begin bad++; $display("FAIL fill_miss got=%0b/%0d exp=0/0", hit, hit_way); end
    endtask

    task automatic test_plru();
        look(3'd3, 28'h0);
        total++; if (victim_way !== 2'd0 || victim_valid !== 1'b1) begin bad++; $display("FAIL plru_full got=%0d/%0b exp=0/1", victim_way, victim_valid); end
        do_upd(2'd0, 3'd3, 2'd0, 28'h0);
        look(3'd3, 28'h0);
        total++; if (victim_way !== 2'd2) begin bad++; $display("FAIL plru_touch0 got=%0d exp=2", victim_way); end
        do_upd(2'd0, 3'd3, 2'd2, 28'h0);
        look(3'd3, 28'h0);
        total++; if (victim_way !== 2'd1) begin bad++; $display("FAIL plru_touch2 got=%0d exp=1", victim_way); end
        do_upd(2'd3, 3'd3, 2'd3, 28'h0);
        look(3'd3, 28'hD);
        total++; if (victim_way !== 2'd3 || victim_valid !== 1'b0) begin bad++; $display("FAIL plru_inval got=%0d/%0b exp=3/0", victim_way, victim_valid); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL inval_hit got=%0b exp=0", hit); end
    endtask

    task automatic test_dirty();
        do_upd(2'd1, 3'd3, 2'd3, 28'hD);
        look(3'd3, 28'h0);
        total++; if (victim_way !== 2'd1) begin bad++; $display("FAIL refill_victim got=%0d exp=1", victim_way); end
        do_upd(2'd2, 3'd3, 2'd1, 28'h0);
        do_upd(2'd0, 3'd3, 2'd0, 28'h0);
        do_upd(2'd0, 3'd3, 2'd3, 28'h0);
        look(3'd3, 28'h0);
        total++; if (victim_way !== 2'd1 || victim_dirty !== 1'b1 || victim_valid !== 1'b1 || victim_tag !== 28'hB) begin
            bad++; $display("FAIL dirty_victim got way=%0d d=%0b v=%0b tag=%0h exp 1/1/1/b", victim_way, victim_dirty, victim_valid, victim_tag);
        end
        look(3'd4, 28'hB);
        total++; if (hit !== 1'b0 || victim_valid !== 1'b0 || victim_dirty !== 1'b0) begin
            bad++; $display("FAIL other_set got hit=%0b v=%0b d=%0b exp 0/0/0", hit, victim_valid, victim_dirty);
        end
        do_upd(2'd1, 3'd5, 2'd0, 28'h77);
        do_upd(2'd2, 3'd5, 2'd0, 28'h0);
    endtask

    task automatic test_flush();
        int busy_cyc, done_cnt, n_off;
        logic [2:0]  i0, i1;
        logic [27:0] t0, t1;
        bit stall_ok, hit_busy, tmo;
        look(3'd3, 28'hB);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        run_flush(3, 1'b0, busy_cyc, done_cnt, n_off, i0, t0, i1, t1, stall_ok, hit_busy, tmo);
        total++; if (tmo) begin bad++; $display("FAIL flush_timeout busy still high after %0d cycles", busy_cyc); end
        total++; if (busy_cyc != 38) begin bad++; $display("FAIL flush_busy_len got=%0d exp=38", busy_cyc); end
        total++; if (done_cnt != 1 || flush_done !== 1'b0) begin bad++; $display("FAIL flush_done_pulse got=%0d exp=1", done_cnt); end
        total++; if (n_off != 2) begin bad++; $display("FAIL flush_offers got=%0d exp=2", n_off); end
        total++; if (i0 !== 3'd3 || t0 !== 28'hB) begin bad++; $display("FAIL flush_offer0 got=%0d/%0h exp=3/b", i0, t0); end
        total++; if (i1 !== 3'd5 || t1 !== 28'h77) begin bad++; $display("FAIL flush_offer1 got=%0d/%0h exp=5/77", i1, t1); end
        total++; if (!stall_ok) begin bad++; $display("FAIL flush_stall_hold got=unstable exp=stable"); end
        total++; if (hit_busy !== 1'b0) begin bad++; $display("FAIL busy_hit got=%0b exp=0", hit_busy); end
        look(3'd3, 28'hB);
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL post_flush_3b got=%0b exp=0", hit); end
        look(3'd5, 28'h77);
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL post_flush_577 got=%0b exp=0", hit); end
        look(3'd3, 28'hA);
        total++; if (hit !== 1'b0 || victim_valid !== 1'b0) begin bad++; $display("FAIL post_flush_3a got=%0b/%0b exp=0/0", hit, victim_valid); end
    endtask

    task automatic test_busy_ignore();
        int busy_cyc, done_cnt, n_off;
        logic [2:0]  i0, i1;
        logic [27:0] t0, t1;
        bit stall_ok, hit_busy, tmo;
        look(3'd0, 28'h55);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        run_flush(0, 1'b1, busy_cyc, done_cnt, n_off, i0, t0, i1, t1, stall_ok, hit_busy, tmo);
        total++; if (tmo || busy_cyc != 33) begin bad++; $display("FAIL busy_restart len got=%0d exp=33", busy_cyc); end
        total++; if (done_cnt != 1 || n_off != 0) begin bad++; $display("FAIL busy_ignore_done got=%0d/%0d exp=1/0", done_cnt, n_off); end
        look(3'd0, 28'h55);
        total++; if (hit !== 1'b0 || victim_valid !== 1'b0) begin bad++; $display("FAIL busy_fill got=%0b/%0b exp=0/0", hit, victim_valid); end
        repeat (2) step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_stays_low got=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int busy_cyc, done_cnt, n_off;
        logic [2:0]  i0, i1;
        logic [27:0] t0, t1;
        bit stall_ok, hit_busy, tmo;
        do_upd(2'd1, 3'd6, 2'd2, 28'h99);
        look(3'd6, 28'h99);
        total++; if (hit !== 1'b1 || hit_way !== 2'd2) begin bad++; $display("FAIL b2b_prefill got=%0b/%0d exp=1/2", hit, hit_way); end
        upd_op = 2'd2; upd_idx = 3'd6; upd_way = 2'd2; upd_en = 1'b1; flush_req = 1'b1;
        step();
        upd_en = 1'b0; flush_req = 1'b0;
        run_flush(0, 1'b0, busy_cyc, done_cnt, n_off, i0, t0, i1, t1, stall_ok, hit_busy, tmo);
        total++; if (tmo || busy_cyc != 34) begin bad++; $display("FAIL b2b_busy_len got=%0d exp=34", busy_cyc); end
        total++; if (n_off != 1 || i0 !== 3'd6 || t0 !== 28'h99) begin
            bad++; $display("FAIL b2b_offer got n=%0d %0d/%0h exp 1 6/99", n_off, i0, t0);
        end
        total++; if (hit_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_hit got=%0b exp=0", hit_busy); end
    endtask

    task automatic test_reset_evict();
        int n;
        do_upd(2'd1, 3'd1, 2'd1, 28'h31);
        do_upd(2'd2, 3'd1, 2'd1, 28'h0);
        flush_evict_rdy = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        n = 0;
        while (flush_evict_val !== 1'b1 && n < 100) begin step(); n++; end
        total++; if (n >= 100 || flush_evict_idx !== 3'd1) begin bad++; $display("FAIL rst_evict_reach n=%0d idx=%0d exp idx=1", n, flush_evict_idx); end
        reset = 1'b1;
        step();
        total++; if (flush_evict_val !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0) begin
            bad++; $display("FAIL rst_evict_outs val=%0b busy=%0b done=%0b exp 000", flush_evict_val, busy, flush_done);
        end
        reset = 1'b0;
        flush_evict_rdy = 1'b1;
        look(3'd1, 28'h31);
        total++; if (hit !== 1'b0 || victim_valid !== 1'b0 || victim_dirty !== 1'b0) begin
            bad++; $display("FAIL rst_evict_lines hit=%0b v=%0b d=%0b exp 000", hit, victim_valid, victim_dirty);
        end
        step();
        total++; if (busy !== 1'b0 || flush_done !== 1'b0) begin bad++; $display("FAIL rst_evict_idle busy=%0b done=%0b exp 00", busy, flush_done); end
    endtask

    initial begin
        reset = 1'b1; lkup_idx = '0; lkup_tag = '0;
        upd_en = 1'b0; upd_op = '0; upd_idx = '0; upd_way = '0; upd_tag = '0;
        flush_req = 1'b0; flush_evict_rdy = 1'b1;
        test_reset();
        test_fill();
        test_plru();
        test_dirty();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_reset_evict();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
